// File: rtl/gt_response_checker.sv
// gt_response_checker: scores an exhaustive sweep of a greater-than comparator.
// Each accepted vector is checked against the expected (a,b) order and against
// the unsigned a>b reference. Error/vector counts and the first failing operands
// are captured, and a pass flag is produced once the last vector is accepted.
module gt_response_checker #(
   parameter int unsigned NUM_BITS = 4,
   parameter int unsigned ERR_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [NUM_BITS-1:0]   in_a,
   input  logic [NUM_BITS-1:0]   in_b,
   input  logic                  in_o,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [2*NUM_BITS:0]   vec_count,
   output logic                  first_err_valid,
   output logic [NUM_BITS-1:0]   first_err_a,
   output logic [NUM_BITS-1:0]   first_err_b
);

   localparam int unsigned AW = 2 * NUM_BITS;
   // Count value held just before the final vector of the sweep is accepted.
   localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic [AW:0]           vec_q, vec_d;
   logic [AW-1:0]         exp_q, exp_d;     // {exp_a, exp_b}: b wraps into a
   logic                  pass_q, pass_d;
   logic                  fev_q, fev_d;
   logic [NUM_BITS-1:0]   fea_q, fea_d;
   logic [NUM_BITS-1:0]   feb_q, feb_d;

   logic                  accept;
   logic                  vec_err;

   // start has priority, so a vector arriving with it is dropped.
   assign accept  = (state_q == S_CHECK) && in_valid && !start;
   assign vec_err = (in_o != (in_a > in_b)) || ({in_a, in_b} != exp_q);

   // Next-state and result update for each accepted vector.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      vec_d   = vec_q;
      exp_d   = exp_q;
      pass_d  = pass_q;
      fev_d   = fev_q;
      fea_d   = fea_q;
      feb_d   = feb_q;
      if (start) begin
         state_d = S_CHECK;
         err_d   = '0;
         vec_d   = '0;
         exp_d   = '0;
         pass_d  = 1'b0;
         fev_d   = 1'b0;
         fea_d   = '0;
         feb_d   = '0;
      end else if (accept) begin
         vec_d = vec_q + (AW+1)'(1);
         exp_d = exp_q + AW'(1);
         if (vec_err) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (!fev_q) begin
               fev_d = 1'b1;
               fea_d = in_a;
               feb_d = in_b;
            end
         end
         if (vec_q == LAST) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
         end
      end
   end

   // State and result registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         err_q   <= '0;
         vec_q   <= '0;
         exp_q   <= '0;
         pass_q  <= 1'b0;
         fev_q   <= 1'b0;
         fea_q   <= '0;
         feb_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         vec_q   <= vec_d;
         exp_q   <= exp_d;
         pass_q  <= pass_d;
         fev_q   <= fev_d;
         fea_q   <= fea_d;
         feb_q   <= feb_d;
      end
   end

   assign busy            = (state_q == S_CHECK);
   assign done            = (state_q == S_DONE);
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign vec_count       = vec_q;
   assign first_err_valid = fev_q;
   assign first_err_a     = fea_q;
   assign first_err_b     = feb_q;

endmodule

// File: tb/tb_gt_response_checker.sv
// Directed bench for gt_response_checker: full sweeps (clean, with errors,
// with gaps, after mid-sweep reset), order errors, restart from DONE, and
// error-counter saturation on a narrow instance.
module tb_gt_response_checker;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [3:0]  in_a;
   logic [3:0]  in_b;
   logic        in_o;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [8:0]  vec_count;
   logic        first_err_valid;
   logic [3:0]  first_err_a;
   logic [3:0]  first_err_b;

   logic        s_start;
   logic        s_valid;
   logic [0:0]  s_a;
   logic [0:0]  s_b;
   logic        s_o;
   logic        s_busy;
   logic        s_done;
   logic        s_pass;
   logic [1:0]  s_err;
   logic [2:0]  s_vec;
   logic        s_fev;
   logic [0:0]  s_fea;
   logic [0:0]  s_feb;

   int unsigned n_vec;
   int unsigned n_miss;

   gt_response_checker #(.NUM_BITS(4), .ERR_W(16)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .in_valid        (in_valid),
      .in_a            (in_a),
      .in_b            (in_b),
      .in_o            (in_o),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .vec_count       (vec_count),
      .first_err_valid (first_err_valid),
      .first_err_a     (first_err_a),
      .first_err_b     (first_err_b)
   );

   gt_response_checker #(.NUM_BITS(1), .ERR_W(2)) u_sat (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (s_start),
      .in_valid        (s_valid),
      .in_a            (s_a),
      .in_b            (s_b),
      .in_o            (s_o),
      .busy            (s_busy),
      .done            (s_done),
      .pass            (s_pass),
      .err_count       (s_err),
      .vec_count       (s_vec),
      .first_err_valid (s_fev),
      .first_err_a     (s_fea),
      .first_err_b     (s_feb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic o);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_o     = o;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Applies vectors 0..count-1 in a-major order; optional faults at (5,3),(9,12).
   task automatic sweep(input int count, input bit gaps, input bit inject);
      logic [3:0] a;
      logic [3:0] b;
      logic       o;
      for (int i = 0; i < count; i++) begin
         a = 4'(i >> 4);
         b = 4'(i);
         o = (a > b);
         if (inject && ((a == 4'd5 && b == 4'd3) || (a == 4'd9 && b == 4'd12))) o = ~o;
         if (i == 255) check_val("done_before_last", 32'(done), 32'd0);
         send(a, b, o);
         if (gaps) begin
            tick();
            if (i == 254) check_val("busy_in_gap", 32'(busy), 32'd1);
         end
      end
   endtask

   task automatic check_clean_done(input string tag);
      check_val({tag, "_done"}, 32'(done), 32'd1);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_pass"}, 32'(pass), 32'd1);
      check_val({tag, "_vec"},  32'(vec_count), 32'd256);
      check_val({tag, "_err"},  32'(err_count), 32'd0);
      check_val({tag, "_fev"},  32'(first_err_valid), 32'd0);
   endtask

   task automatic s_send(input logic a, input logic b, input logic o);
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      s_o     = o;
      tick();
      s_valid = 1'b0;
   endtask

   initial begin
      n_vec    = 0;
      n_miss   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_o     = 1'b0;
      s_start  = 1'b0;
      s_valid  = 1'b0;
      s_a      = '0;
      s_b      = '0;
      s_o      = 1'b0;

      // Reset state
      tick();
      tick();
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_pass", 32'(pass), 32'd0);
      check_val("rst_err",  32'(err_count), 32'd0);
      check_val("rst_vec",  32'(vec_count), 32'd0);
      check_val("rst_fev",  32'(first_err_valid), 32'd0);
      check_val("rst_fea",  32'(first_err_a), 32'd0);
      check_val("rst_feb",  32'(first_err_b), 32'd0);
      rst_n = 1'b1;
      tick();

      // in_valid ignored in IDLE
      send(4'd0, 4'd0, 1'b0);
      check_val("idle_vec",  32'(vec_count), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);

      // start with in_valid: vector dropped
      in_valid = 1'b1;
      pulse_start();
      in_valid = 1'b0;
      check_val("start_busy", 32'(busy), 32'd1);
      check_val("start_vec",  32'(vec_count), 32'd0);

      // Clean back-to-back sweep
      sweep(256, 1'b0, 1'b0);
      check_clean_done("clean");
      send(4'd1, 4'd0, 1'b1);
      check_val("done_ignores_vec", 32'(vec_count), 32'd256);
      tick();
      check_val("done_hold", 32'(done), 32'd1);

      // Sweep with two wrong responses
      pulse_start();
      sweep(256, 1'b0, 1'b1);
      check_val("bad_done", 32'(done), 32'd1);
      check_val("bad_err",  32'(err_count), 32'd2);
      check_val("bad_pass", 32'(pass), 32'd0);
      check_val("bad_fev",  32'(first_err_valid), 32'd1);
      check_val("bad_fea",  32'(first_err_a), 32'd5);
      check_val("bad_feb",  32'(first_err_b), 32'd3);
      check_val("bad_vec",  32'(vec_count), 32'd256);

      // Restart from DONE with errors present, concurrent vector dropped
      in_valid = 1'b1;
      in_a     = 4'd0;
      in_b     = 4'd0;
      in_o     = 1'b0;
      pulse_start();
      in_valid = 1'b0;
      check_val("restart_busy", 32'(busy), 32'd1);
      check_val("restart_done", 32'(done), 32'd0);
      check_val("restart_err",  32'(err_count), 32'd0);
      check_val("restart_vec",  32'(vec_count), 32'd0);
      check_val("restart_fev",  32'(first_err_valid), 32'd0);

      // Order error: (0,0) then (0,2)
      send(4'd0, 4'd0, 1'b0);
      check_val("ord_vec1", 32'(vec_count), 32'd1);
      check_val("ord_err1", 32'(err_count), 32'd0);
      send(4'd0, 4'd2, 1'b0);
      check_val("ord_vec2", 32'(vec_count), 32'd2);
      check_val("ord_err2", 32'(err_count), 32'd1);
      check_val("ord_fev",  32'(first_err_valid), 32'd1);
      check_val("ord_fea",  32'(first_err_a), 32'd0);
      check_val("ord_feb",  32'(first_err_b), 32'd2);
      // (0,3) arrives while (0,2) is expected, and in_o is wrong too: one error
      send(4'd0, 4'd3, 1'b1);
      check_val("dbl_err", 32'(err_count), 32'd2);
      check_val("dbl_feb", 32'(first_err_b), 32'd2);

      // Sweep with in_valid every other cycle
      pulse_start();
      sweep(256, 1'b1, 1'b0);
      check_clean_done("gap");

      // Reset mid-sweep, then a fresh clean sweep
      pulse_start();
      sweep(100, 1'b0, 1'b0);
      check_val("mid_vec", 32'(vec_count), 32'd100);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_busy", 32'(busy), 32'd0);
      check_val("async_vec",  32'(vec_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send(4'd0, 4'd0, 1'b0);
      check_val("post_rst_idle_vec", 32'(vec_count), 32'd0);
      pulse_start();
      sweep(256, 1'b0, 1'b0);
      check_clean_done("after_rst");

      // Error counter saturation on 1-bit operands, 2-bit counter
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_send(1'b0, 1'b0, 1'b1);
      s_send(1'b0, 1'b1, 1'b1);
      s_send(1'b1, 1'b0, 1'b0);
      check_val("sat_err3", 32'(s_err), 32'd3);
      check_val("sat_done3", 32'(s_done), 32'd0);
      s_send(1'b1, 1'b1, 1'b1);
      check_val("sat_err4",  32'(s_err), 32'd3);
      check_val("sat_vec",   32'(s_vec), 32'd4);
      check_val("sat_done",  32'(s_done), 32'd1);
      check_val("sat_pass",  32'(s_pass), 32'd0);
      check_val("sat_fev",   32'(s_fev), 32'd1);
      check_val("sat_fea",   32'(s_fea), 32'd0);
      check_val("sat_feb",   32'(s_feb), 32'd0);
      check_val("sat_busy",  32'(s_busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
